// File: rtl/arbitro_round_robin.sv
// rtl/arbitro_round_robin.sv - eight-way round-robin arbiter with hold timeout and one-hot grant
module arbitro_round_robin #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    state_t            state_n;
    logic [2:0]        ptr;
    logic [2:0]        ptr_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_n;
    logic [7:0]        grant_n;
    logic [2:0]        grant_idx_n;
    logic              grant_valid_n;
    logic              timeout_n;

    logic [2:0]        winner;
    logic              owner_req;
    logic              hold_last;

    // First set bit scanning upward from p and wrapping past 7 back to 0.
    function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] result;
        logic       found;
        result = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign winner    = pick_winner(req, ptr);
    assign owner_req = req[grant_idx];
    assign hold_last = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= '0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_cnt_n;
            grant       <= grant_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
            timeout     <= timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        hold_cnt_n    = hold_cnt;
        grant_n       = grant;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        timeout_n     = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_n       = GRANT;
                    grant_idx_n   = winner;
                    grant_n       = 8'b1 << winner;
                    grant_valid_n = 1'b1;
                    hold_cnt_n    = '0;
                end else begin
                    grant_idx_n   = 3'd0;
                    grant_n       = 8'h00;
                    grant_valid_n = 1'b0;
                    hold_cnt_n    = '0;
                end
            end
            GRANT: begin
                // A release on the last hold cycle wins over the timeout.
                if (!owner_req || hold_last) begin
                    state_n       = IDLE;
                    ptr_n         = grant_idx + 3'd1;
                    grant_idx_n   = 3'd0;
                    grant_n       = 8'h00;
                    grant_valid_n = 1'b0;
                    hold_cnt_n    = '0;
                    timeout_n     = owner_req;
                end else begin
                    hold_cnt_n    = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n       = IDLE;
                grant_idx_n   = 3'd0;
                grant_n       = 8'h00;
                grant_valid_n = 1'b0;
                hold_cnt_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_arbitro_round_robin.sv
// tb/tb_arbitro_round_robin.sv - self-checking bench for arbitro_round_robin
module tb_arbitro_round_robin;

    localparam int MH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int n_to     = 0;

    arbitro_round_robin #(.MAX_HOLD(MH), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner, number of cycles it has held, next search start.
    logic m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_held  = 0;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_owner <= 0; m_held <= 0; m_ptr <= 0; m_to <= 1'b0;
        end else if (!m_busy) begin
            m_to <= 1'b0;
            if (req != 8'h00) begin
                m_busy  <= 1'b1;
                m_owner <= pick(req, m_ptr);
                m_held  <= 1;
            end
        end else begin
            m_to <= 1'b0;
            if (!req[m_owner] || m_held == MH) begin
                m_busy  <= 1'b0;
                m_ptr   <= (m_owner + 1) % 8;
                m_owner <= 0;
                m_to    <= req[m_owner];
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_grant", int'(grant), m_busy ? (1 << m_owner) : 0);
        check("model_idx", int'(grant_idx), m_busy ? m_owner : 0);
        check("model_valid", int'(grant_valid), int'(m_busy));
        check("model_timeout", int'(timeout), int'(m_to));
        check("onehot_or_zero", int'($countones(grant) <= 1), 1);
        if (grant_valid) check("grant_eq_idx", int'(grant), 1 << grant_idx);
        else             check("idle_grant_zero", int'(grant), 0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_grant", int'(grant), 0);
        check("reset_idx", int'(grant_idx), 0);
        check("reset_valid", int'(grant_valid), 0);
        check("reset_timeout", int'(timeout), 0);
        rst_n = 1'b1;

        // single requester, grant one cycle after sampling, then release
        req = 8'h01;
        @(negedge clk);
        check("t1_grant", int'(grant), 1);
        check("t1_idx", int'(grant_idx), 0);
        check("t1_valid", int'(grant_valid), 1);
        req = 8'h00;
        @(negedge clk);
        check("t1_release_grant", int'(grant), 0);
        check("t1_release_valid", int'(grant_valid), 0);

        // two requesters alternate through timeouts, pointer wraps 7->0
        do_reset();
        req = 8'h81;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 5 || i == 10) begin
                check("t2_idle_valid", int'(grant_valid), 0);
                check("t2_idle_timeout", int'(timeout), 1);
            end else begin
                check("t2_valid", int'(grant_valid), 1);
                check("t2_idx", int'(grant_idx), (i >= 6 && i <= 9) ? 7 : 0);
                check("t2_timeout", int'(timeout), 0);
            end
        end

        // all requesting, each winner drops after one cycle
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t3_idx", int'(grant_idx), k);
            check("t3_valid", int'(grant_valid), 1);
            req[k] = 1'b0;
            @(negedge clk);
            check("t3_gap_grant", int'(grant), 0);
        end

        // sole requester held: grants of MH cycles, timeout each MH+1
        do_reset();
        req  = 8'h04;
        n_to = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout) n_to++;
            check("t4_timeout", int'(timeout), (i % 5 == 0) ? 1 : 0);
            check("t4_grant", int'(grant), (i % 5 == 0) ? 0 : 8'h04);
        end
        check("t4_timeout_count", n_to, 8);
        req = 8'h00;

        // asynchronous reset in third grant cycle clears pointer
        do_reset();
        req = 8'h20;
        @(negedge clk);
        check("t5_idx", int'(grant_idx), 5);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_grant", int'(grant), 0);
        check("t5_async_valid", int'(grant_valid), 0);
        @(negedge clk);
        req = 8'h21;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_idx", int'(grant_idx), 0);
        check("t5_after_valid", int'(grant_valid), 1);

        // release exactly on the last hold cycle: no timeout
        do_reset();
        req = 8'h01;
        for (int i = 1; i <= MH; i++) begin
            @(negedge clk);
            check("t6_valid", int'(grant_valid), 1);
        end
        req = 8'h00;
        @(negedge clk);
        check("t6_grant", int'(grant), 0);
        check("t6_timeout", int'(timeout), 0);

        // random traffic against the model, with occasional async resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
